// File: rtl/laser_host_driver_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : laser_host_driver_if
//  Brief    : Signal bundle between the host driver, its register write port
//             and the two-circle laser coverage engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface laser_host_driver_if;
    // Point-memory write port and run request
    logic       WR_EN;
    logic [5:0] WR_ADDR;
    logic [3:0] WR_X;
    logic [3:0] WR_Y;
    logic       START;
    // Engine link
    logic       LASER_RST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       LASER_DONE;
    logic [3:0] L_C1X;
    logic [3:0] L_C1Y;
    logic [3:0] L_C2X;
    logic [3:0] L_C2Y;
    // Status and result
    logic       BUSY;
    logic [5:0] SCORE;
    logic       SCORE_VALID;
    logic       TIMEOUT_ERR;

    // The driver itself
    modport slave (
        input  WR_EN, WR_ADDR, WR_X, WR_Y, START,
        input  LASER_DONE, L_C1X, L_C1Y, L_C2X, L_C2Y,
        output LASER_RST, X, Y, BUSY, SCORE, SCORE_VALID, TIMEOUT_ERR
    );

    // Host plus engine, seen from outside the driver
    modport master (
        output WR_EN, WR_ADDR, WR_X, WR_Y, START,
        output LASER_DONE, L_C1X, L_C1Y, L_C2X, L_C2Y,
        input  LASER_RST, X, Y, BUSY, SCORE, SCORE_VALID, TIMEOUT_ERR
    );
endinterface
`default_nettype wire

// File: rtl/laser_host_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : laser_host_driver
//  Brief    : Loads a target point set, runs the laser coverage engine over
//             it, captures the two reported centres and re-scores them by
//             counting points inside the union of the two circles.
//  Revision : 1.0 - initial release
// ============================================================================
module laser_host_driver #(
    parameter int NPTS    = 40,
    parameter int R_SQ    = 16,
    parameter int TIMEOUT = 1023
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    laser_host_driver_if.slave   bus
);

    localparam int         WAIT_W      = $clog2(TIMEOUT + 1);
    localparam logic [5:0] C_LAST      = 6'(NPTS - 1);
    localparam logic [5:0] C_NPTS      = 6'(NPTS);
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [8:0] C_RSQ       = 9'(R_SQ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LRST      = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_SCORE     = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    state_t            r_state, w_state_next;
    logic [5:0]        r_cnt, w_cnt_next;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic              w_start_run;
    logic              w_done_ok;
    logic              w_timeout;

    logic [3:0] r_mem_x [0:NPTS-1];
    logic [3:0] r_mem_y [0:NPTS-1];

    logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;
    logic [5:0] r_acc, w_acc_next;

    logic       r_laser_rst, r_busy, r_score_valid, r_timeout_err;
    logic [3:0] r_x, r_y;
    logic [5:0] r_score;

    // |a-b| by selecting the larger operand first, so nothing ever wraps
    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [7:0] square(input logic [3:0] d);
        return {4'd0, d} * {4'd0, d};
    endfunction

    // Scoring datapath: evaluate the point indexed by the run counter
    logic [3:0] w_px, w_py;
    logic [8:0] w_d1, w_d2;
    logic       w_hit;

    // Distance of the current point to both latched centres
    always_comb begin
        w_px  = r_mem_x[r_cnt];
        w_py  = r_mem_y[r_cnt];
        w_d1  = {1'b0, square(abs_diff(r_c1x, w_px))} + {1'b0, square(abs_diff(r_c1y, w_py))};
        w_d2  = {1'b0, square(abs_diff(r_c2x, w_px))} + {1'b0, square(abs_diff(r_c2y, w_py))};
        w_hit = (w_d1 <= C_RSQ) || (w_d2 <= C_RSQ);
        w_acc_next = r_acc + {5'd0, w_hit};
    end

    // FSM state, point counter and wait counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state logic and per-transition event flags
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wait_next  = r_wait;
        w_start_run  = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_start_run  = 1'b1;
                    w_state_next = S_LRST;
                    w_cnt_next   = '0;
                end
            end
            S_LRST: begin
                w_state_next = S_STREAM;
                w_cnt_next   = '0;
            end
            S_STREAM: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = S_WAIT_DONE;
                    w_cnt_next   = '0;
                    w_wait_next  = '0;
                end else begin
                    w_cnt_next   = r_cnt + 6'd1;
                end
            end
            S_WAIT_DONE: begin
                // DONE wins over an expiring counter in the same cycle
                if (bus.LASER_DONE) begin
                    w_done_ok    = 1'b1;
                    w_state_next = S_SCORE;
                    w_cnt_next   = '0;
                end else if (r_wait == C_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_REPORT;
                end else begin
                    w_wait_next  = r_wait + 1'b1;
                end
            end
            S_SCORE: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = S_REPORT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 6'd1;
                end
            end
            S_REPORT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Point memory: host writes only while idle and in range
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NPTS; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
            end
        end else if (r_state == S_IDLE && bus.WR_EN && bus.WR_ADDR < C_NPTS) begin
            r_mem_x[bus.WR_ADDR] <= bus.WR_X;
            r_mem_y[bus.WR_ADDR] <= bus.WR_Y;
        end
    end

    // Centre capture on DONE and score accumulation
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_c1x <= '0;
            r_c1y <= '0;
            r_c2x <= '0;
            r_c2y <= '0;
            r_acc <= '0;
        end else begin
            if (w_done_ok) begin
                r_c1x <= bus.L_C1X;
                r_c1y <= bus.L_C1Y;
                r_c2x <= bus.L_C2X;
                r_c2y <= bus.L_C2Y;
            end
            if (w_start_run)
                r_acc <= '0;
            else if (r_state == S_SCORE)
                r_acc <= w_acc_next;
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_laser_rst   <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_busy        <= 1'b0;
            r_score_valid <= 1'b0;
            r_score       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_laser_rst   <= (w_state_next == S_LRST);
            r_busy        <= (w_state_next != S_IDLE);
            r_score_valid <= (w_state_next == S_REPORT);
            if (w_state_next == S_STREAM) begin
                r_x <= r_mem_x[w_cnt_next];
                r_y <= r_mem_y[w_cnt_next];
            end else begin
                r_x <= '0;
                r_y <= '0;
            end
            if (w_start_run) begin
                r_score       <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                if (r_state == S_SCORE && w_state_next == S_REPORT)
                    r_score <= w_acc_next;
                if (w_timeout)
                    r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.LASER_RST   = r_laser_rst;
    assign bus.X           = r_x;
    assign bus.Y           = r_y;
    assign bus.BUSY        = r_busy;
    assign bus.SCORE       = r_score;
    assign bus.SCORE_VALID = r_score_valid;
    assign bus.TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_laser_host_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_laser_host_driver
//  Brief    : Directed self-checking bench for laser_host_driver with a
//             simple engine model that answers DONE with fixed centres.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_laser_host_driver;

    localparam int NPTS    = 40;
    localparam int TIMEOUT = 1023;

    logic clk;
    logic rst;
    laser_host_driver_if bus ();

    laser_host_driver #(.NPTS(NPTS), .R_SQ(16), .TIMEOUT(TIMEOUT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model of the point memory contents
    logic [3:0] ex [0:NPTS-1];
    logic [3:0] ey [0:NPTS-1];

    task automatic load_all(input logic [3:0] x, input logic [3:0] y);
        for (int i = 0; i < NPTS; i++) begin
            @(posedge clk); #1;
            bus.WR_EN = 1'b1; bus.WR_ADDR = 6'(i); bus.WR_X = x; bus.WR_Y = y;
            ex[i] = x; ey[i] = y;
        end
        @(posedge clk); #1;
        bus.WR_EN = 1'b0;
    endtask

    task automatic write_pt(input int a, input logic [3:0] x, input logic [3:0] y);
        @(posedge clk); #1;
        bus.WR_EN = 1'b1; bus.WR_ADDR = 6'(a); bus.WR_X = x; bus.WR_Y = y;
        ex[a] = x; ey[a] = y;
        @(posedge clk); #1;
        bus.WR_EN = 1'b0;
    endtask

    // One full run: START, stream check, engine answer, report check.
    // done_dly == 0 means the engine never answers.
    task automatic run_case(input string name, input int done_dly,
                            input logic [3:0] c1x, input logic [3:0] c1y,
                            input logic [3:0] c2x, input logic [3:0] c2y,
                            input int exp_score, input logic exp_to,
                            input bit sw, input int sw_a, input logic [3:0] sw_x, input logic [3:0] sw_y,
                            input bit inj_wr, input bit inj_start);
        int first_bad;
        logic [3:0] bx, by;
        int n, n_exp;
        bit seen;
        first_bad = -1; bx = 0; by = 0;
        @(posedge clk); #1;
        bus.START = 1'b1;
        if (sw) begin
            bus.WR_EN = 1'b1; bus.WR_ADDR = 6'(sw_a); bus.WR_X = sw_x; bus.WR_Y = sw_y;
            ex[sw_a] = sw_x; ey[sw_a] = sw_y;
        end
        @(posedge clk); #1;
        bus.START = 1'b0; bus.WR_EN = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.LASER_RST !== 1'b1 || bus.X !== 4'd0 || bus.Y !== 4'd0 || bus.BUSY !== 1'b1)
            $display("FAIL %s lrst: rst=%b x=%0d y=%0d busy=%b expected 1 0 0 1",
                     name, bus.LASER_RST, bus.X, bus.Y, bus.BUSY);
        else pass_cnt++;
        for (int k = 0; k < NPTS; k++) begin
            @(negedge clk);
            if ((bus.X !== ex[k] || bus.Y !== ey[k] || bus.LASER_RST !== 1'b0) && first_bad < 0) begin
                first_bad = k; bx = bus.X; by = bus.Y;
            end
            if (inj_wr && k == 0) begin
                bus.WR_EN = 1'b1; bus.WR_ADDR = 6'd3; bus.WR_X = 4'd12; bus.WR_Y = 4'd12;
            end
            if (inj_wr && k == 1) bus.WR_EN = 1'b0;
        end
        total_cnt++;
        if (first_bad >= 0)
            $display("FAIL %s stream: point %0d got (%0d,%0d) expected (%0d,%0d)",
                     name, first_bad, bx, by, ex[first_bad], ey[first_bad]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.X !== 4'd0 || bus.Y !== 4'd0 || bus.BUSY !== 1'b1)
            $display("FAIL %s wait_idle_xy: x=%0d y=%0d busy=%b expected 0 0 1",
                     name, bus.X, bus.Y, bus.BUSY);
        else pass_cnt++;
        if (done_dly > 0) begin
            repeat (done_dly - 1) @(posedge clk);
            #1;
            bus.LASER_DONE = 1'b1;
            bus.L_C1X = c1x; bus.L_C1Y = c1y; bus.L_C2X = c2x; bus.L_C2Y = c2y;
            @(posedge clk); #1;
            bus.LASER_DONE = 1'b0;
            n_exp = NPTS + 1;
        end else begin
            n_exp = TIMEOUT;
        end
        n = 0; seen = 0;
        while (!seen && n < 1200) begin
            @(negedge clk);
            n++;
            if (inj_start && n == 5) bus.START = 1'b1;
            if (inj_start && n == 6) bus.START = 1'b0;
            if (bus.SCORE_VALID === 1'b1) seen = 1;
        end
        total_cnt++;
        if (!seen || n != n_exp)
            $display("FAIL %s latency: valid_seen=%0d after %0d cycles expected %0d",
                     name, seen, n, n_exp);
        else pass_cnt++;
        total_cnt++;
        if (bus.SCORE !== 6'(exp_score))
            $display("FAIL %s score: got %0d expected %0d", name, bus.SCORE, exp_score);
        else pass_cnt++;
        total_cnt++;
        if (bus.TIMEOUT_ERR !== exp_to)
            $display("FAIL %s timeout_err: got %b expected %b", name, bus.TIMEOUT_ERR, exp_to);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.SCORE_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.SCORE !== 6'(exp_score) ||
            bus.TIMEOUT_ERR !== exp_to)
            $display("FAIL %s after_report: valid=%b busy=%b score=%0d to=%b expected 0 0 %0d %b",
                     name, bus.SCORE_VALID, bus.BUSY, bus.SCORE, bus.TIMEOUT_ERR, exp_score, exp_to);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.LASER_RST !== 1'b0 || bus.X !== 4'd0 || bus.Y !== 4'd0 || bus.BUSY !== 1'b0)
            $display("FAIL reset_ctrl: rst=%b x=%0d y=%0d busy=%b expected all 0",
                     bus.LASER_RST, bus.X, bus.Y, bus.BUSY);
        else pass_cnt++;
        total_cnt++;
        if (bus.SCORE !== 6'd0 || bus.SCORE_VALID !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0)
            $display("FAIL reset_result: score=%0d valid=%b to=%b expected 0 0 0",
                     bus.SCORE, bus.SCORE_VALID, bus.TIMEOUT_ERR);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < NPTS; i++) begin ex[i] = 4'd0; ey[i] = 4'd0; end
    endtask

    task automatic test_zero_points();
        // Memory comes from reset, so all points are (0,0)
        run_case("zero", 5, 4'd15, 4'd15, 4'd15, 4'd0, 0, 1'b0,
                 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_all_hit();
        load_all(4'd5, 4'd5);
        run_case("all_hit", 5, 4'd5, 4'd5, 4'd0, 4'd0, 40, 1'b0,
                 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        load_all(4'd15, 4'd15);
        write_pt(0, 4'd9, 4'd5);
        write_pt(1, 4'd9, 4'd6);
        // Point 2 = (1,5) is written in the same cycle as START
        run_case("boundary", 5, 4'd5, 4'd5, 4'd15, 4'd15, 39, 1'b0,
                 1'b1, 2, 4'd1, 4'd5, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        load_all(4'd7, 4'd7);
        run_case("overlap", 5, 4'd7, 4'd7, 4'd8, 4'd7, 40, 1'b0,
                 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        run_case("timeout", 0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b1,
                 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_write_during_stream();
        // Rejected write of (12,12) to point 3 would make it a miss
        run_case("wr_stream", 3, 4'd7, 4'd7, 4'd0, 4'd0, 40, 1'b0,
                 1'b0, 0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid_stream();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.LASER_RST !== 1'b0 || bus.X !== 4'd0 || bus.Y !== 4'd0 || bus.BUSY !== 1'b0 ||
            bus.SCORE !== 6'd0 || bus.SCORE_VALID !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0)
            $display("FAIL rst_mid outputs: rst=%b x=%0d y=%0d busy=%b score=%0d valid=%b to=%b expected all 0",
                     bus.LASER_RST, bus.X, bus.Y, bus.BUSY, bus.SCORE, bus.SCORE_VALID, bus.TIMEOUT_ERR);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < NPTS; i++) begin ex[i] = 4'd0; ey[i] = 4'd0; end
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            bus.LASER_DONE = (c == 40);
            if (bus.SCORE_VALID !== 1'b0 || bus.BUSY !== 1'b0) bad++;
        end
        bus.LASER_DONE = 1'b0;
        total_cnt++;
        if (bad != 0)
            $display("FAIL rst_mid idle: %0d cycles with valid/busy set, expected 0", bad);
        else pass_cnt++;
        // Memory was cleared: (0,0) points all sit on C1=(0,0)
        run_case("post_rst", 4, 4'd0, 4'd0, 4'd15, 4'd15, 40, 1'b0,
                 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_X = '0; bus.WR_Y = '0;
        bus.START = 1'b0; bus.LASER_DONE = 1'b0;
        bus.L_C1X = '0; bus.L_C1Y = '0; bus.L_C2X = '0; bus.L_C2Y = '0;
        test_reset();
        test_zero_points();
        test_all_hit();
        test_boundary();
        test_overlap();
        test_timeout();
        test_write_during_stream();
        test_rst_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/laser_host_driver.md
Name: laser_host_driver

Overview:
- Host-side counterpart of the two-circle laser coverage engine.
- Holds a 40-point target set loaded by a register write port.
- Resets the engine, streams one (X,Y) point per cycle, waits for its DONE, then captures C1/C2.
- Independently re-scores the answer: counts points covered by the union of the two radius-4 circles and reports the score. Used as the system-level driver and self-check for the engine.

Parameters:
- NPTS, 40, number of target points streamed and scored.
- R_SQ, 16, squared radius; a point is covered when dx*dx+dy*dy <= R_SQ.
- TIMEOUT, 1023, maximum cycles spent in WAIT_DONE before the run is abandoned.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  point-memory write strobe.
- WR_ADDR  in  6  point index.
- WR_X  in  4  point X coordinate.
- WR_Y  in  4  point Y coordinate.
- START  in  1  single-cycle run request.
- LASER_RST  out  1  reset to the engine, registered.
- X  out  4  streamed point X, registered.
- Y  out  4  streamed point Y, registered.
- LASER_DONE  in  1  engine completion.
- L_C1X, L_C1Y, L_C2X, L_C2Y  in  4 each  engine result.
- BUSY  out  1  high in every state except IDLE.
- SCORE  out  6  covered-point count.
- SCORE_VALID  out  1  one-cycle result strobe.
- TIMEOUT_ERR  out  1  set when the engine did not finish.

Behaviour:
- Reset: state IDLE. Outputs LASER_RST, X, Y, BUSY, SCORE, SCORE_VALID and TIMEOUT_ERR are all 0. Point memory is cleared to (0,0). Captured centres and all counters are cleared. RST overrides all activity, including a run in progress; no SCORE_VALID is emitted for an aborted run.
- Writes:
  - Accepted only in IDLE with WR_ADDR < NPTS; otherwise ignored.
  - Write data is visible at the next edge.
  - START and WR_EN in the same IDLE cycle: the write takes effect and the run uses the new value.
- FSM states: IDLE, LRST, STREAM, WAIT_DONE, SCORE, REPORT.
- IDLE: on START=1, go to LRST. START outside IDLE is ignored.
  - Entering LRST clears TIMEOUT_ERR and SCORE.
- LRST: lasts 1 cycle. LASER_RST=1, X=Y=0.
- STREAM: lasts NPTS cycles. In stream cycle k (k=0..NPTS-1), X/Y = mem[k].
  - START sampled at edge e gives: LASER_RST high in the cycle after e; point 0 in the cycle after that; point 39 exactly 41 cycles after e.
  - LASER_DONE is ignored in LRST and STREAM.
- WAIT_DONE: X=Y=0. The timeout counter starts at 0 on entry.
  - LASER_DONE=1: latch L_C1X..L_C2Y and go to SCORE.
  - Counter reaches TIMEOUT with no DONE: set TIMEOUT_ERR=1, keep SCORE=0, go to REPORT.
  - DONE arriving in the same cycle the counter reaches TIMEOUT counts as success.
- SCORE: lasts NPTS cycles. Evaluate one point per cycle against the latched centres.
  - dx = |cx - px| as 4-bit unsigned, computed with a compare-select, never by wrapping subtraction.
  - dx*dx and dy*dy are 8 bits each; their sum is 9 bits.
  - A point is a hit if d1 <= R_SQ OR d2 <= R_SQ. A point inside both circles counts once.
  - The accumulator is 6 bits; its maximum is NPTS, so it never overflows.
- REPORT: lasts 1 cycle. SCORE_VALID=1 and SCORE is driven with the final count, then go to IDLE.
  - SCORE and TIMEOUT_ERR hold until the next START.
- Success latency: 2 + NPTS + (wait cycles) + NPTS + 1 from START to SCORE_VALID.

Test Plan:
- All 40 points at (5,5); engine model returns C1=(5,5), C2=(0,0) on DONE 5 cycles after the last point -> X/Y sequence correct cycle by cycle, SCORE=40, SCORE_VALID exactly 1 cycle, TIMEOUT_ERR=0.
- All points at (0,0); C1=(15,15), C2=(15,0) -> SCORE=0.
- Radius boundary with C1=(5,5), C2=(15,15):
  - point 0 = (9,5) (d²=16) -> hit.
  - point 1 = (9,6) (d²=17) -> miss.
  - point 2 = (1,5) (d²=16, exercises the abs-diff path) -> hit.
  - remaining points at (15,15) -> hits.
  - Expected SCORE=39.
- Overlap: C1=(7,7), C2=(8,7), all points at (7,7) -> SCORE=40, no double count.
- LASER_DONE never asserted -> REPORT after exactly TIMEOUT WAIT_DONE cycles, with TIMEOUT_ERR=1, SCORE=0, SCORE_VALID=1.
- Robustness:
  - WR_EN to index 3 during STREAM -> mem unchanged and the streamed value is the old one.
  - START during SCORE -> ignored.
  - RST asserted mid-STREAM -> all outputs 0 next cycle, IDLE, and no SCORE_VALID.
